// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - round-robin arbiter and sequencer for a shared combinational add/sub unit
module addsub_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             m0,
    input  logic             m1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH:0]   res,
    output logic             busy,
    output logic [WIDTH-1:0] au_a,
    output logic [WIDTH-1:0] au_b,
    output logic             au_m,
    input  logic [WIDTH:0]   au_sum
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   ptr;
    logic   win;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req0 || req1) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Winner: sole requester, or the one the priority pointer names on contention.
    always_comb begin
        win = 1'b0;
        if (req0 && req1) begin
            win = ptr;
        end else if (req1) begin
            win = 1'b1;
        end
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= 1'b0;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            res   <= '0;
            au_a  <= '0;
            au_b  <= '0;
            au_m  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        gnt0 <= ~win;
                        gnt1 <= win;
                        au_a <= win ? a1 : a0;
                        au_b <= win ? b1 : b0;
                        au_m <= win ? m1 : m0;
                    end
                end
                EXEC: begin
                    res   <= au_sum;
                    done0 <= gnt0;
                    done1 <= gnt1;
                end
                RESP: begin
                    // Point away from the requester just served.
                    ptr   <= ~gnt1;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                end
                default: begin
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Sequencing controller and two-port arbiter for the shared 4-bit parallel adder/subtractor (`Para_ADD_SUB`).
- Two requesters each submit an operand pair and a mode bit.
- The block grants the unit round-robin, drives its operands from registers and captures its 5-bit result.
- It returns the result with a one-cycle done pulse.
- It sits between client datapaths and the single arithmetic unit, so the unit is never driven by two sources at once.

## Interface
Parameters:
- `WIDTH`, default 4: operand width. The result is `WIDTH+1` bits.

Ports:
- `clk` input 1: single clock; all state is updated on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `req0`, `req1` input 1 each: request from requester 0 or 1. Held high until that requester's done pulse.
- `a0`, `b0`, `a1`, `b1` input `WIDTH` each: operands for each requester. Sampled only at grant.
- `m0`, `m1` input 1 each: mode per requester. 0 selects add, 1 selects subtract (A−B).
- `gnt0`, `gnt1` output 1 each: registered, one-hot grant. High for the whole operation.
- `done0`, `done1` output 1 each: one-cycle pulse when the result is valid.
- `res` output `WIDTH+1`: captured unit result. Held until the next capture.
- `busy` output 1: high whenever state ≠ IDLE.
- `au_a`, `au_b` output `WIDTH` each: registered operands driven to the unit's `A1`/`B1`.
- `au_m` output 1: registered mode driven to the unit's `M`.
- `au_sum` input `WIDTH+1`: unit's `sum2`, a combinational function of `au_a`, `au_b` and `au_m`.

## Operation
Unit arithmetic:
- When `au_m`=0, `au_sum` = `au_a` + `au_b`; bit 4 is the carry.
- When `au_m`=1, `au_sum` = `au_a` + ~`au_b` + 1; bit 4 = 1 means no borrow.
- The block passes `au_sum` through unmodified into `res`.

State machine: IDLE → EXEC → RESP → IDLE.
- IDLE:
  - If either `req` is high, select a winner.
  - Latch the winner's operands and mode into `au_a`, `au_b` and `au_m`.
  - Set its `gnt`, then go to EXEC.
  - With no request, stay in IDLE; `au_*` keep their last values.
- EXEC:
  - Operands are stable at the unit.
  - On the edge leaving EXEC, load `res` from `au_sum`; next state is RESP.
- RESP:
  - Assert `done` for the granted requester and keep its `gnt` high.
  - Toggle the priority pointer so it points away from the requester just served.
  - Next state is IDLE; `gnt` and `done` clear on that edge.
- Arbitration:
  - If only one `req` is high, that requester wins.
  - If both are high, the requester named by the priority pointer wins.
  - The pointer resets to requester 0.
- A `req` still high in IDLE after its done pulse counts as a new request.
- Input changes during EXEC or RESP have no effect; operands are captured only at grant.
- Reset (at any time, including mid-operation):
  - State → IDLE, pointer → 0.
  - `gnt0`, `gnt1`, `done0`, `done1` and `busy` → 0.
  - `res`, `au_a` and `au_b` → 0, and `au_m` → 0.
  - An in-flight operation is discarded and no done pulse is issued for it.

## Timing
- Request sampled high at edge 0 (state IDLE):
  - After edge 0: `gnt` and `busy` are high and `au_*` are valid.
  - After edge 1: `res` is valid and `done` is high.
  - After edge 2: back in IDLE.
- Throughput is one operation per 3 cycles.
- Both requesters held high alternate: 0, 1, 0, 1, …
- The requester must drop `req` by the edge after it sees `done`. Otherwise it is regranted at that edge.
- `au_sum` must settle within one cycle of `au_*` changing; the unit is combinational.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → every output reads 0 immediately, with no clock edge needed.
- **Add on port 0:** `req0` with `a0`=1111, `b0`=1111, `m0`=0 → `gnt0` is high 1 cycle after sampling; `done0` pulses 2 cycles after with `res`=11110.
- **Subtract on port 1:** `req1` with `a1`=1111, `b1`=0111, `m1`=1 → `res`=11000, `done1` is a single-cycle pulse, and `done0` stays 0.
- **Simultaneous requests after reset:**
  - `req0` carries 0100+0101 (`m0`=0); `req1` carries 1000−1111 (`m1`=1).
  - Port 0 is served first with `res`=01001, then port 1 with `res`=01001 (borrow shown by bit 4 = 0).
  - Keep both held → the next grant goes to 0 and then alternates.
- **Reset in EXEC:** grant port 0, then pulse `rst` during EXEC → no `done0`; after release with `req0` still high, a fresh grant occurs with correct 3-cycle timing.
- **Operand change after grant:** change `a0` during EXEC → `res` reflects the value latched at grant.
